// File: rtl/addr_decoder_n.sv
// Serial-address bus decoder: shifts in a slave address LSB first, then grants the
// master a path to one of NUM_SLAVES slaves, with NACK, busy-wait, timeout and abort.
module addr_decoder_n #(
    parameter int DEVICE_ADDR_WIDTH = 4,
    parameter int NUM_SLAVES        = 3,
    parameter int SSEL_WIDTH        = 2,
    parameter int TIMEOUT           = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  mwdata,
    input  logic                  mvalid,
    input  logic [NUM_SLAVES-1:0] sready,
    output logic [NUM_SLAVES-1:0] mvalid_out,
    output logic [SSEL_WIDTH-1:0] ssel,
    output logic                  ack,
    output logic                  nack
);

    localparam int BCNT_W = $clog2(DEVICE_ADDR_WIDTH);
    localparam int TCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int AEXT_W = DEVICE_ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DECODE,
        HOLD,
        CONNECT,
        WAIT
    } stateT;

    stateT                        r_state;
    logic [DEVICE_ADDR_WIDTH-1:0] r_addr;
    logic [BCNT_W-1:0]            r_bitCnt;
    logic [TCNT_W-1:0]            r_tCnt;
    logic [SSEL_WIDTH-1:0]        r_ssel;
    logic                         r_nack;

    logic w_connected;
    logic w_addrValid;
    logic w_readyAtAddr;
    logic w_readyAtSsel;
    logic w_tLast;

    assign w_connected = (r_state == CONNECT) || (r_state == WAIT);
    // Widen by one bit so NUM_SLAVES == 2**DEVICE_ADDR_WIDTH does not truncate to zero.
    assign w_addrValid = {1'b0, r_addr} < AEXT_W'(NUM_SLAVES);
    assign w_tLast     = (TIMEOUT != 0) && (r_tCnt == TCNT_W'(TIMEOUT - 1));
    assign ack         = (r_state == CONNECT);
    assign nack        = r_nack;
    assign ssel        = r_ssel;

    always_comb begin
        w_readyAtAddr = 1'b0;
        w_readyAtSsel = 1'b0;
        mvalid_out    = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_addr == DEVICE_ADDR_WIDTH'(i)) begin
                w_readyAtAddr = sready[i];
            end
            if (r_ssel == SSEL_WIDTH'(i)) begin
                w_readyAtSsel = sready[i];
                mvalid_out[i] = mvalid & w_connected;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_bitCnt <= '0;
            r_tCnt   <= '0;
            r_ssel   <= '0;
            r_nack   <= 1'b0;
        end else begin
            r_nack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mvalid) begin
                        r_addr   <= {{(DEVICE_ADDR_WIDTH-1){1'b0}}, mwdata};
                        r_bitCnt <= BCNT_W'(1);
                        r_state  <= ADDR;
                    end
                end
                ADDR: begin
                    if (!mvalid) begin
                        r_state <= IDLE;
                    end else begin
                        r_addr[r_bitCnt] <= mwdata;
                        if (r_bitCnt == BCNT_W'(DEVICE_ADDR_WIDTH - 1)) begin
                            r_bitCnt <= '0;
                            r_state  <= DECODE;
                        end else begin
                            r_bitCnt <= r_bitCnt + 1'b1;
                        end
                    end
                end
                DECODE: begin
                    r_tCnt <= '0;
                    if (!w_addrValid) begin
                        r_nack  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_ssel  <= r_addr[SSEL_WIDTH-1:0];
                        r_state <= w_readyAtAddr ? CONNECT : HOLD;
                    end
                end
                HOLD: begin
                    if (!mvalid) begin
                        r_state <= IDLE;
                    end else if (w_readyAtSsel) begin
                        r_tCnt  <= '0;
                        r_state <= CONNECT;
                    end else if (w_tLast) begin
                        r_nack  <= 1'b1;
                        r_state <= IDLE;
                    end else if (r_tCnt != {TCNT_W{1'b1}}) begin
                        r_tCnt <= r_tCnt + 1'b1;
                    end
                end
                CONNECT: begin
                    if (mvalid) begin
                        r_state <= WAIT;
                    end else if (w_tLast) begin
                        r_nack  <= 1'b1;
                        r_state <= IDLE;
                    end else if (r_tCnt != {TCNT_W{1'b1}}) begin
                        r_tCnt <= r_tCnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (!mvalid) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addr_decoder_n.sv
// Self-checking bench for addr_decoder_n: table of single transactions plus
// hand-written HOLD, timeout, abort and async-reset sequences, checked via a scoreboard queue.
module tb_addr_decoder_n;

    logic       clk = 1'b0;
    logic       rstn;
    logic       mwdata;
    logic       mvalid;
    logic [2:0] sready;
    logic [2:0] mvalid_out;
    logic [1:0] ssel;
    logic       ack;
    logic       nack;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic       ack;
        logic       nack;
        logic [2:0] mvo;
        logic [1:0] ssel;
        logic       sselCare;
    } expT;

    typedef struct {
        int         addr;
        logic [2:0] rdy;
        logic       isAck;
        logic [2:0] mvo;
        logic [1:0] ssel;
    } vecT;

    expT sbQ[$];

    addr_decoder_n #(
        .DEVICE_ADDR_WIDTH(4),
        .NUM_SLAVES       (3),
        .SSEL_WIDTH       (2),
        .TIMEOUT          (16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .mwdata    (mwdata),
        .mvalid    (mvalid),
        .sready    (sready),
        .mvalid_out(mvalid_out),
        .ssel      (ssel),
        .ack       (ack),
        .nack      (nack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkField(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input expT e);
        checkField({e.name, ".ack"}, int'(ack), int'(e.ack));
        checkField({e.name, ".nack"}, int'(nack), int'(e.nack));
        checkField({e.name, ".mvalid_out"}, int'(mvalid_out), int'(e.mvo));
        if (e.sselCare) checkField({e.name, ".ssel"}, int'(ssel), int'(e.ssel));
    endtask

    // Expected results are popped mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
    end

    task automatic applyStimulus(input logic mv, input logic wd, input logic [2:0] rdy);
        @(posedge clk);
        #1;
        mvalid = mv;
        mwdata = wd;
        sready = rdy;
    endtask

    task automatic cycleExp(input string name, input logic mv, input logic wd, input logic [2:0] rdy,
                            input logic a, input logic n, input logic [2:0] mo,
                            input logic [1:0] s, input logic care);
        expT e;
        applyStimulus(mv, wd, rdy);
        e.name = name; e.ack = a; e.nack = n; e.mvo = mo; e.ssel = s; e.sselCare = care;
        sbQ.push_back(e);
    endtask

    // Cycles 0..3 shift the address, cycle 4 is DECODE.
    task automatic sendAddr(input string name, input int addr, input logic [2:0] rdy, input logic decodeMv);
        logic [3:0] a;
        a = 4'(addr);
        for (int i = 0; i < 4; i++) cycleExp({name, ".bit"}, 1'b1, a[i], rdy, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0);
        cycleExp({name, ".decode"}, decodeMv, 1'b0, rdy, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0);
    endtask

    // Cycles 5..8 of a granted transaction: CONNECT, WAIT, drop, IDLE.
    task automatic finishAck(input string name, input logic [2:0] rdy, input logic [2:0] mo, input logic [1:0] s);
        cycleExp({name, ".connect"}, 1'b1, 1'b0, rdy, 1'b1, 1'b0, mo, s, 1'b1);
        cycleExp({name, ".wait"}, 1'b1, 1'b0, rdy, 1'b0, 1'b0, mo, s, 1'b1);
        cycleExp({name, ".drop"}, 1'b0, 1'b0, rdy, 1'b0, 1'b0, 3'b000, s, 1'b1);
        cycleExp({name, ".idle"}, 1'b0, 1'b0, rdy, 1'b0, 1'b0, 3'b000, s, 1'b1);
    endtask

    initial begin
        vecT vecs[10];
        string nm;

        vecs[0] = '{addr: 0,  rdy: 3'b111, isAck: 1'b1, mvo: 3'b001, ssel: 2'd0};
        vecs[1] = '{addr: 1,  rdy: 3'b111, isAck: 1'b1, mvo: 3'b010, ssel: 2'd1};
        vecs[2] = '{addr: 2,  rdy: 3'b111, isAck: 1'b1, mvo: 3'b100, ssel: 2'd2};
        vecs[3] = '{addr: 1,  rdy: 3'b010, isAck: 1'b1, mvo: 3'b010, ssel: 2'd1};
        vecs[4] = '{addr: 5,  rdy: 3'b111, isAck: 1'b0, mvo: 3'b000, ssel: 2'd0};
        vecs[5] = '{addr: 3,  rdy: 3'b111, isAck: 1'b0, mvo: 3'b000, ssel: 2'd0};
        vecs[6] = '{addr: 8,  rdy: 3'b111, isAck: 1'b0, mvo: 3'b000, ssel: 2'd0};
        vecs[7] = '{addr: 15, rdy: 3'b000, isAck: 1'b0, mvo: 3'b000, ssel: 2'd0};
        vecs[8] = '{addr: 0,  rdy: 3'b001, isAck: 1'b1, mvo: 3'b001, ssel: 2'd0};
        vecs[9] = '{addr: 2,  rdy: 3'b100, isAck: 1'b1, mvo: 3'b100, ssel: 2'd2};

        rstn = 1'b0; mvalid = 1'b0; mwdata = 1'b0; sready = 3'b000;
        #2;
        checkField("reset.ack", int'(ack), 0);
        checkField("reset.nack", int'(nack), 0);
        checkField("reset.mvalid_out", int'(mvalid_out), 0);
        checkField("reset.ssel", int'(ssel), 0);
        @(posedge clk);
        #3 rstn = 1'b1;

        for (int v = 0; v < 10; v++) begin
            nm = $sformatf("vec%0d", v);
            sendAddr(nm, vecs[v].addr, vecs[v].rdy, 1'b1);
            if (vecs[v].isAck) begin
                finishAck(nm, vecs[v].rdy, vecs[v].mvo, vecs[v].ssel);
            end else begin
                cycleExp({nm, ".nack"}, 1'b0, 1'b0, vecs[v].rdy, 1'b0, 1'b1, 3'b000, 2'd0, 1'b0);
                cycleExp({nm, ".after"}, 1'b0, 1'b0, vecs[v].rdy, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0);
            end
        end

        // Slave 2 busy until four cycles after DECODE.
        sendAddr("hold", 2, 3'b011, 1'b1);
        for (int c = 5; c < 8; c++) cycleExp("hold.wait", 1'b1, 1'b0, 3'b011, 1'b0, 1'b0, 3'b000, 2'd2, 1'b1);
        cycleExp("hold.rise", 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 2'd2, 1'b1);
        finishAck("hold", 3'b111, 3'b100, 2'd2);

        // Slave 0 never ready: 16 HOLD cycles then a single nack.
        sendAddr("htmo", 0, 3'b110, 1'b1);
        for (int c = 5; c < 21; c++) cycleExp("htmo.hold", 1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 3'b000, 2'd0, 1'b1);
        cycleExp("htmo.nack", 1'b0, 1'b0, 3'b110, 1'b0, 1'b1, 3'b000, 2'd0, 1'b1);
        cycleExp("htmo.after", 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 3'b000, 2'd0, 1'b1);

        // Granted but master idle in CONNECT for 16 cycles.
        sendAddr("ctmo", 1, 3'b111, 1'b0);
        for (int c = 5; c < 21; c++) cycleExp("ctmo.connect", 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 3'b000, 2'd1, 1'b1);
        cycleExp("ctmo.nack", 1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 3'b000, 2'd1, 1'b1);
        cycleExp("ctmo.after", 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 2'd1, 1'b1);

        // Abort after two bits of 1s, then a clean address 1.
        cycleExp("abort.b0", 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0);
        cycleExp("abort.b1", 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0);
        cycleExp("abort.drop", 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0);
        cycleExp("abort.idle", 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0);
        sendAddr("abort.retry", 1, 3'b111, 1'b1);
        finishAck("abort.retry", 3'b111, 3'b010, 2'd1);

        // Async reset in the middle of WAIT, between clock edges.
        sendAddr("rst", 1, 3'b111, 1'b1);
        cycleExp("rst.connect", 1'b1, 1'b0, 3'b111, 1'b1, 1'b0, 3'b010, 2'd1, 1'b1);
        cycleExp("rst.wait", 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        checkField("rst.async.ack", int'(ack), 0);
        checkField("rst.async.nack", int'(nack), 0);
        checkField("rst.async.mvalid_out", int'(mvalid_out), 0);
        checkField("rst.async.ssel", int'(ssel), 0);
        @(posedge clk);
        #3;
        mvalid = 1'b0;
        rstn = 1'b1;
        cycleExp("rst.idle", 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 2'd0, 1'b1);
        sendAddr("rst.new", 2, 3'b111, 1'b1);
        finishAck("rst.new", 3'b111, 3'b100, 2'd2);

        @(negedge clk);
        #1;
        checkField("sb.drained", sbQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addr_decoder_n.md
Name: addr_decoder_n

Overview:
Parametrised successor to the bus address decoder. It receives a serial slave address from the master on the write-data line and routes the master valid to one of NUM_SLAVES slaves. It adds out-of-range NACK, waiting on a busy slave (per-slave ready), timeouts, and abort when the master drops valid mid-address. It sits between the master port and the slave-side valid/data muxes of the system bus.

Parameters:
DEVICE_ADDR_WIDTH, 4, serial slave-address length in bits (must be >= 2)
NUM_SLAVES, 3, number of attached slaves (2..2**DEVICE_ADDR_WIDTH)
SSEL_WIDTH, 2, slave-select width, equal to clog2(NUM_SLAVES)
TIMEOUT, 16, maximum cycles spent in HOLD or CONNECT; 0 disables the timeout

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  reset, asynchronous, active-low
mwdata  input  1  serial address bit from master, LSB first
mvalid  input  1  master valid
sready  input  NUM_SLAVES  per-slave ready (slave can accept a new transaction)
mvalid_out  output  NUM_SLAVES  one-hot valid to slaves
ssel  output  SSEL_WIDTH  slave select to muxes (registered)
ack  output  1  connection granted
nack  output  1  one-cycle pulse: address invalid or timeout

Behaviour:
- Reset (async, rstn=0): state=IDLE, address register=0, bit counter=0, timeout counter=0, ssel=0, nack=0. Combinational ack=0 and mvalid_out=0 follow immediately. Reset mid-transaction drops every output at once, with no ack or nack.
- States: IDLE, ADDR, DECODE, HOLD, CONNECT, WAIT.
- IDLE: if mvalid=1, capture addr[0]<=mwdata, set bit counter=1, go to ADDR.
- ADDR: each cycle, addr[counter]<=mwdata and counter++. When counter==DEVICE_ADDR_WIDTH-1, capture the last bit and go to DECODE. If mvalid=0 in any ADDR cycle, go to IDLE (abort; no nack, no ack).
- DECODE (1 cycle): if addr>=NUM_SLAVES, set nack<=1 for exactly one cycle (visible the cycle after DECODE) and go to IDLE. Otherwise ssel<=addr[SSEL_WIDTH-1:0], clear the timeout counter, and go to CONNECT if sready[addr]=1, else HOLD.
- HOLD: wait for sready[ssel]=1, then go to CONNECT with the timeout counter cleared. The timeout counter increments each cycle. On reaching TIMEOUT (TIMEOUT!=0), pulse nack and go to IDLE. If mvalid=0, go to IDLE silently. If sready and timeout coincide, sready wins.
- CONNECT: ack=1 (Moore, combinational from state). If mvalid=1, go to WAIT. Otherwise stay, incrementing the timeout counter; on reaching TIMEOUT, pulse nack and go to IDLE.
- WAIT: ack=0. Hold ssel. When mvalid=0, go to IDLE.
- mvalid_out[i] = mvalid & (state==CONNECT or WAIT) & (ssel==i). Exactly one bit is high at most, and it is never high outside CONNECT/WAIT.
- Latency: first address bit in cycle 0 (IDLE). DECODE in cycle DEVICE_ADDR_WIDTH. Earliest ack in cycle DEVICE_ADDR_WIDTH+1. An invalid-address nack also lands in cycle DEVICE_ADDR_WIDTH+1.
- ack and nack are never high in the same cycle.
- The address register is unchanged outside IDLE/ADDR.
- ssel retains its last value in IDLE.
- The counter widths hold DEVICE_ADDR_WIDTH-1 and TIMEOUT without wrap. The timeout counter saturates and never wraps.
- Back-to-back transactions: WAIT->IDLE when mvalid falls. A new mvalid rise in the next cycle starts a fresh address; there is no required idle gap beyond that one IDLE cycle.

Test Plan:
- Defaults, sready=3'b111, serial address 1 (bits 1,0,0,0) with mvalid held: ack=1 in cycle 5, ssel=1, mvalid_out=3'b010 in CONNECT/WAIT; mvalid drop gives mvalid_out=0 and IDLE next cycle.
- Serial address 5: nack=1 for exactly cycle 5, ack never asserted, mvalid_out stays 0, returns to IDLE.
- Address 2 with sready[2]=0 until 4 cycles after DECODE: FSM in HOLD, ack=0, mvalid_out=0; ack asserts the cycle after sready[2] rises; mvalid_out=3'b100.
- Address 0 with sready[0] held 0 and TIMEOUT=16: nack pulses once after 16 HOLD cycles, then IDLE. Separately, ack with mvalid held 0 for 16 cycles in CONNECT gives nack and drops ack.
- mvalid deasserted after 2 address bits: returns to IDLE, no ack/nack. A subsequent full address 1 decodes correctly, with no stale bits affecting the result.
- rstn pulled low asynchronously mid-WAIT (between clock edges): mvalid_out, ack, nack=0 and ssel=0 immediately. After release, a new transaction to address 2 succeeds.
